// File: rtl/password_enroll_pkg.sv
// Shared types and constants for the password enrollment block.
package password_enroll_pkg;

    localparam int PSWD_DIGITS = 4;
    localparam int PSWD_W      = 16;
    localparam int DIGIT_W     = 4;
    localparam int CNT_W       = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTER   = 3'd1,
        S_CONFIRM = 3'd2,
        S_WRITE   = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_DENIED   = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_DIGIT    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/password_enroll_digit_packer.sv
// Shifts decimal digits into a 16-bit word, first digit in the top nibble.
module digit_packer
    import password_enroll_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] digit,
    output logic [PSWD_W-1:0]  value,
    output logic [PSWD_W-1:0]  shifted,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    // shifted is the word as it will look once this digit lands, so the
    // caller can act on a complete password in the same cycle.
    assign shifted = {value[PSWD_W-DIGIT_W-1:0], digit};
    assign full    = load && (count == CNT_W'(PSWD_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= shifted;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/password_enroll.sv
// Password change controller: collect, confirm, then write to the password store.
module password_enroll
    import password_enroll_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int TO_W           = 29
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Start,
    input  logic [DIGIT_W-1:0] UserDigit,
    input  logic               UserLoad,
    input  logic               LoggedIn,
    input  logic [2:0]         PlayerID,
    input  logic               isGuest,
    output logic               WrEn,
    output logic [2:0]         WrAddr,
    output logic [PSWD_W-1:0]  WrData,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [1:0]         ErrCode,
    output logic [2:0]         dbg_state
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t              state, next_state;
    logic [1:0]          err_next;
    logic [PSWD_W-1:0]   new_pw;
    logic [TO_W-1:0]     to_cnt;
    logic                in_session, accept, digit_ok, bad_digit;
    logic                pk_clear, pk_full;
    logic [PSWD_W-1:0]   pk_value, pk_shifted;
    logic [CNT_W-1:0]    pk_count;

    assign in_session = (state == S_ENTER) || (state == S_CONFIRM);
    assign accept     = (state == S_IDLE) && Start && LoggedIn && !isGuest;
    assign bad_digit  = in_session && LoggedIn && UserLoad && !is_digit(UserDigit);
    assign digit_ok   = in_session && LoggedIn && UserLoad && is_digit(UserDigit);
    assign pk_clear   = (state == S_IDLE) || ((state == S_ENTER) && pk_full);
    assign dbg_state  = state;

    digit_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .clear   (pk_clear),
        .load    (digit_ok),
        .digit   (UserDigit),
        .value   (pk_value),
        .shifted (pk_shifted),
        .count   (pk_count),
        .full    (pk_full)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Priority: logout, invalid digit, valid digit, timeout.
    always_comb begin
        next_state = state;
        err_next   = ErrCode;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (LoggedIn && !isGuest) begin
                        next_state = S_ENTER;
                    end else begin
                        next_state = S_FAIL;
                        err_next   = ERR_DENIED;
                    end
                end
            end
            S_ENTER, S_CONFIRM: begin
                if (!LoggedIn) begin
                    next_state = S_IDLE;
                end else if (bad_digit) begin
                    next_state = S_FAIL;
                    err_next   = ERR_DIGIT;
                end else if (digit_ok) begin
                    if (pk_full) begin
                        if (state == S_ENTER) begin
                            next_state = S_CONFIRM;
                        end else if (pk_shifted == new_pw) begin
                            next_state = S_WRITE;
                        end else begin
                            next_state = S_FAIL;
                            err_next   = ERR_MISMATCH;
                        end
                    end
                end else if (to_cnt == TO_LAST) begin
                    next_state = S_FAIL;
                    err_next   = ERR_TIMEOUT;
                end
            end
            S_WRITE, S_FAIL: next_state = S_IDLE;
            default:         next_state = S_IDLE;
        endcase
    end

    always_comb begin
        WrEn  = (state == S_WRITE);
        Done  = (state == S_WRITE);
        Error = (state == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Busy    <= 1'b0;
            ErrCode <= ERR_DENIED;
            WrAddr  <= '0;
            WrData  <= '0;
            new_pw  <= '0;
            to_cnt  <= '0;
        end else begin
            ErrCode <= err_next;
            if (accept) WrAddr <= PlayerID;
            if ((state == S_ENTER) && pk_full) new_pw <= pk_shifted;
            if (next_state == S_WRITE) WrData <= new_pw;
            if (accept || digit_ok)  to_cnt <= '0;
            else if (in_session)     to_cnt <= to_cnt + 1'b1;
            // A denied Start passes through FAIL without ever looking busy.
            Busy <= (next_state == S_ENTER) || (next_state == S_CONFIRM) ||
                    (next_state == S_WRITE) ||
                    ((next_state == S_FAIL) && (state != S_IDLE));
        end
    end

endmodule
